hazard_ctrl_param: RTL and testbench
====================================

// Module: hazard_ctrl_param
// PURPOSE
//  Parametrised pipeline hazard controller for the pipelined MIPS core.
//  Combines ID-stage operand forwarding over NFWD producer stages, load-use detection,
//  cache stall aggregation and a multi-cycle MUL/DIV scoreboard.
//  Drives per-stage stall/bubble controls and keeps saturating per-cause stall-cycle counters.
//  Sits beside IF/ID/EX/MEM/WB and is the only source of their stall/bubble inputs.
// PARAMETERS
//  AW         5   register-index width
//  NFWD       3   forwarding sources; index 0 = youngest (EX), then MEM, WB, ...
//  SELW       2   forward-select width; must satisfy 2**SELW >= NFWD+1
//  MD_LAT     4   MUL/DIV busy cycles after issue (>=1)
//  CNT_W      32  perf counter width
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           synchronous reset, active-high
//  icache_stall  in   1           I-cache miss in progress
//  dcache_stall  in   1           D-cache miss in progress
//  id_rs, id_rt  in   AW each     ID source register indices
//  id_use_rs     in   1           ID instruction reads rs
//  id_use_rt     in   1           ID instruction reads rt
//  src_we        in   NFWD        per-source RegWrite
//  src_rw        in   NFWD*AW     per-source dest index, source k at [k*AW +: AW]
//  ex_mem_read   in   1           EX instruction is a load
//  id_md_start   in   1           ID instruction issues MUL/DIV
//  id_md_read    in   1           ID instruction reads HI/LO
//  perf_clr      in   1           clear all perf counters
//  fwd_x, fwd_y  out  SELW each   0 = regfile, k = source k-1
//  stall_if      out  1           hold PC
//  stall_id      out  1           hold IF/ID register
//  bubble_id     out  1           load NOP into ID/EX
//  stall_ex      out  1           hold ID/EX register
//  stall_mem     out  1           hold EX/MEM register, tied 0
//  stall_wb      out  1           hold MEM/WB register, tied 0
//  md_busy       out  1           MUL/DIV unit in BUSY
//  md_done       out  1           one-cycle pulse, result valid
//  cnt_dc, cnt_ic, cnt_lu, cnt_md  out  CNT_W each  stall-cycle counters per cause
// BEHAVIOUR
//  Reset:
//   - State=IDLE, md counter=0, all perf counters=0.
//   - While rst=1 all outputs are 0, combinational ones included.
//  Forwarding (combinational, 0 latency):
//   - Per operand, select the lowest index k with src_we[k], src_rw_k!=0 and src_rw_k==operand.
//   - Output k+1 for that match; output 0 if no source matches. r0 is never forwarded.
//  Hazard terms:
//   - lu: ex_mem_read & src_rw_0!=0 & ((id_use_rs & src_rw_0==id_rs) | (id_use_rt & src_rw_0==id_rt)).
//   - mdh: state==BUSY & (id_md_start | id_md_read).
//  Stall priority (first match wins):
//   - dcache_stall: stall_if=stall_id=stall_ex=1, bubble_id=0.
//   - mdh: stall_if=stall_id=1, bubble_id=1, stall_ex=0.
//   - lu: same as mdh.
//   - icache_stall: same as mdh.
//   - none: all 0.
//  MD FSM:
//   - IDLE->BUSY when id_md_start & ~stall_id; counter loads MD_LAT-1.
//   - BUSY: counter decrements every cycle, independent of stalls.
//   - At counter==0: md_done=1 that cycle, next state IDLE.
//   - md_busy = (state==BUSY).
//   - Start accepted at cycle t: BUSY t+1..t+MD_LAT; md_done at t+MD_LAT; HI/LO read unstalled from t+MD_LAT+1.
//  Perf counters:
//   - Exactly one counter, the winning cause, increments per stalled cycle.
//   - Counters saturate at all-ones.
//   - perf_clr overrides increment; counter reads 0 next cycle.
//  rst asserted mid-MD: FSM returns to IDLE, md_done is not produced.
// TESTING
//  - src_we=3'b111, src_rw={5,5,5}, id_rs=5 -> fwd_x=1; src_we=3'b110 -> fwd_x=2; id_rs=0 -> fwd_x=0.
//  - ex_mem_read=1, src_rw_0=8, id_rt=8, id_use_rt=1 -> stall_if=stall_id=bubble_id=1, cnt_lu +1; with id_use_rt=0 -> no stall.
//  - dcache_stall=1 together with lu=1 -> stall_ex=1, bubble_id=0; only cnt_dc increments.
//  - id_md_start at t (MD_LAT=4) -> md_busy t+1..t+4, md_done at t+4; id_md_read at t+2 stalled, at t+5 not stalled.
//  - Hold icache_stall for 2**CNT_W+3 cycles (CNT_W=4 build) -> cnt_ic=15; perf_clr pulse -> 0 next cycle.
//  - rst=1 at t+2 of an MD op -> md_busy=0 at t+3, no md_done; all stall outputs 0 during rst.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// rtl/hazard_ctrl_param.sv - pipeline hazard controller: forwarding, load-use, cache stalls, MUL/DIV scoreboard
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   icache_stall, dcache_stall    cache miss in progress
//   id_rs, id_rt, id_use_rs/rt    ID source operands and their use flags
//   src_we, src_rw                per forwarding source RegWrite / dest index (source k at [k*AW +: AW])
//   ex_mem_read                   EX instruction is a load
//   id_md_start, id_md_read       ID issues MUL/DIV / reads HI-LO
//   perf_clr                      clear all stall counters
//   fwd_x, fwd_y                  0 = regfile, k = source k-1
//   stall_if/id/ex/mem/wb         per-stage hold controls
//   bubble_id                     inject NOP into ID/EX
//   md_busy, md_done              MUL/DIV unit state / completion pulse
//   cnt_dc, cnt_ic, cnt_lu, cnt_md saturating stall-cycle counters per cause
module hazard_ctrl_param #(
    parameter int AW     = 5,
    parameter int NFWD   = 3,
    parameter int SELW   = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               icache_stall,
    input  logic               dcache_stall,
    input  logic [AW-1:0]      id_rs,
    input  logic [AW-1:0]      id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic [NFWD-1:0]    src_we,
    input  logic [NFWD*AW-1:0] src_rw,
    input  logic               ex_mem_read,
    input  logic               id_md_start,
    input  logic               id_md_read,
    input  logic               perf_clr,
    output logic [SELW-1:0]    fwd_x,
    output logic [SELW-1:0]    fwd_y,
    output logic               stall_if,
    output logic               stall_id,
    output logic               bubble_id,
    output logic               stall_ex,
    output logic               stall_mem,
    output logic               stall_wb,
    output logic               md_busy,
    output logic               md_done,
    output logic [CNT_W-1:0]   cnt_dc,
    output logic [CNT_W-1:0]   cnt_ic,
    output logic [CNT_W-1:0]   cnt_lu,
    output logic [CNT_W-1:0]   cnt_md
);

    localparam int MDCW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    typedef enum logic {S_IDLE, S_BUSY} md_state_t;

    // cause indices into the counter array
    localparam int C_DC = 0;
    localparam int C_IC = 1;
    localparam int C_LU = 2;
    localparam int C_MD = 3;

    md_state_t        md_state, md_state_n;
    logic [MDCW-1:0]  md_cnt, md_cnt_n;
    logic [CNT_W-1:0] perf_q [4];

    logic [SELW-1:0]  fx, fy;
    logic [AW-1:0]    rw0;
    logic             lu, mdh;
    logic [3:0]       cause;
    logic             front_stall;
    logic             md_last;

    // Forwarding: scan from oldest to youngest so the lowest index wins.
    always_comb begin
        fx = '0;
        fy = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (src_we[k] && (src_rw[k*AW +: AW] != '0)) begin
                if (src_rw[k*AW +: AW] == id_rs) fx = SELW'(k + 1);
                if (src_rw[k*AW +: AW] == id_rt) fy = SELW'(k + 1);
            end
        end
    end

    assign rw0     = src_rw[AW-1:0];
    assign md_last = (md_state == S_BUSY) && (md_cnt == '0);

    assign lu  = ex_mem_read && (rw0 != '0) &&
                 ((id_use_rs && (rw0 == id_rs)) || (id_use_rt && (rw0 == id_rt)));
    assign mdh = (md_state == S_BUSY) && (id_md_start || id_md_read);

    // Priority resolution: exactly one cause is charged per stalled cycle.
    always_comb begin
        cause       = '0;
        front_stall = 1'b1;
        if (dcache_stall)      cause[C_DC] = 1'b1;
        else if (mdh)          cause[C_MD] = 1'b1;
        else if (lu)           cause[C_LU] = 1'b1;
        else if (icache_stall) cause[C_IC] = 1'b1;
        else                   front_stall = 1'b0;
    end

    // MD FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state <= S_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_n;
            md_cnt   <= md_cnt_n;
        end
    end

    // MD FSM: next state. A start is accepted only when ID actually advances.
    always_comb begin
        md_state_n = md_state;
        md_cnt_n   = md_cnt;
        case (md_state)
            S_IDLE: begin
                if (id_md_start && !front_stall) begin
                    md_state_n = S_BUSY;
                    md_cnt_n   = MDCW'(MD_LAT - 1);
                end
            end
            S_BUSY: begin
                if (md_cnt == '0) md_state_n = S_IDLE;
                else              md_cnt_n   = md_cnt - MDCW'(1);
            end
            default: md_state_n = S_IDLE;
        endcase
    end

    // Outputs: everything is forced low while reset is held.
    always_comb begin
        fwd_x     = rst ? '0 : fx;
        fwd_y     = rst ? '0 : fy;
        stall_if  = !rst && front_stall;
        stall_id  = !rst && front_stall;
        bubble_id = !rst && front_stall && !cause[C_DC];
        stall_ex  = !rst && cause[C_DC];
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        md_busy   = !rst && (md_state == S_BUSY);
        md_done   = !rst && md_last;
        cnt_dc    = rst ? '0 : perf_q[C_DC];
        cnt_ic    = rst ? '0 : perf_q[C_IC];
        cnt_lu    = rst ? '0 : perf_q[C_LU];
        cnt_md    = rst ? '0 : perf_q[C_MD];
    end

    // Saturating stall-cycle counters; clear beats increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || perf_clr)
                perf_q[i] <= '0;
            else if (cause[i] && (perf_q[i] != '1))
                perf_q[i] <= perf_q[i] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb/tb_hazard_ctrl_param.sv - directed self-checking bench for hazard_ctrl_param
module tb_hazard_ctrl_param;

    localparam int AW = 5, NFWD = 3, SELW = 2, MD_LAT = 4, CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               icache_stall, dcache_stall;
    logic [AW-1:0]      id_rs, id_rt;
    logic               id_use_rs, id_use_rt;
    logic [NFWD-1:0]    src_we;
    logic [NFWD*AW-1:0] src_rw;
    logic               ex_mem_read, id_md_start, id_md_read, perf_clr;
    logic [SELW-1:0]    fwd_x, fwd_y;
    logic               stall_if, stall_id, bubble_id, stall_ex, stall_mem, stall_wb;
    logic               md_busy, md_done;
    logic [CNT_W-1:0]   cnt_dc, cnt_ic, cnt_lu, cnt_md;

    always #5 clk = ~clk;

    hazard_ctrl_param #(
        .AW(AW), .NFWD(NFWD), .SELW(SELW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .src_we(src_we), .src_rw(src_rw), .ex_mem_read(ex_mem_read),
        .id_md_start(id_md_start), .id_md_read(id_md_read), .perf_clr(perf_clr),
        .fwd_x(fwd_x), .fwd_y(fwd_y),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_id(bubble_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .md_busy(md_busy), .md_done(md_done),
        .cnt_dc(cnt_dc), .cnt_ic(cnt_ic), .cnt_lu(cnt_lu), .cnt_md(cnt_md)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_val(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icache_stall = 0; dcache_stall = 0;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        src_we = 0; src_rw = 0; ex_mem_read = 0;
        id_md_start = 0; id_md_read = 0; perf_clr = 0;
    endtask

    initial begin
        // reset with hazards present: every output must still read 0
        idle_inputs();
        rst = 1; icache_stall = 1; dcache_stall = 1; id_md_start = 1;
        src_we = 3'b111; src_rw = {5'd5, 5'd5, 5'd5}; id_rs = 5;
        step(); step();
        expect_val("rst_stall_if", 0); expect_val("rst_stall_ex", 0);
        expect_val("rst_fwd_x", 0);    expect_val("rst_md_busy", 0);
        expect_val("rst_cnt_dc", 0);
        check(stall_if); check(stall_ex); check(fwd_x); check(md_busy); check(cnt_dc);

        rst = 0; idle_inputs();
        step();

        // forwarding priority
        src_we = 3'b111; src_rw = {5'd5, 5'd5, 5'd5}; id_rs = 5; id_rt = 5; #1;
        expect_val("fwd_x_ex", 1); expect_val("fwd_y_ex", 1);
        check(fwd_x); check(fwd_y);
        src_we = 3'b110; #1;
        expect_val("fwd_x_mem", 2); check(fwd_x);
        src_we = 3'b100; #1;
        expect_val("fwd_x_wb", 3); check(fwd_x);
        src_we = 3'b110; id_rs = 0; #1;
        expect_val("fwd_x_rs0", 0); check(fwd_x);
        src_we = 3'b111; src_rw = 0; id_rs = 0; #1;
        expect_val("fwd_x_r0_never", 0); expect_val("fwd_no_stall", 0);
        check(fwd_x); check(stall_if);
        idle_inputs();
        step();

        // load-use on rt
        ex_mem_read = 1; src_we = 3'b001; src_rw = {5'd0, 5'd0, 5'd8};
        id_rs = 3; id_rt = 8; id_use_rt = 1; #1;
        expect_val("lu_stall_if", 1); expect_val("lu_stall_id", 1);
        expect_val("lu_bubble", 1);   expect_val("lu_stall_ex", 0);
        expect_val("lu_fwd_y", 1);
        check(stall_if); check(stall_id); check(bubble_id); check(stall_ex); check(fwd_y);
        expect_val("lu_cnt", 1);
        step();
        check(cnt_lu);
        id_use_rt = 0; #1;
        expect_val("lu_unused_stall_if", 0); expect_val("lu_unused_stall_id", 0);
        check(stall_if); check(stall_id);
        step();

        // dcache outranks load-use
        id_use_rt = 1; dcache_stall = 1; #1;
        expect_val("dc_stall_ex", 1); expect_val("dc_bubble", 0); expect_val("dc_stall_if", 1);
        check(stall_ex); check(bubble_id); check(stall_if);
        expect_val("dc_cnt_dc", 1); expect_val("dc_cnt_lu", 1);
        expect_val("dc_cnt_ic", 0); expect_val("dc_cnt_md", 0);
        step();
        check(cnt_dc); check(cnt_lu); check(cnt_ic); check(cnt_md);
        idle_inputs();
        step();

        // MUL/DIV: start at t
        id_md_start = 1; #1;
        expect_val("md_t_busy", 0); expect_val("md_t_stall_id", 0);
        check(md_busy); check(stall_id);
        step();                                   // t+1
        id_md_start = 0; #1;
        expect_val("md_t1_busy", 1); expect_val("md_t1_done", 0);
        check(md_busy); check(md_done);
        step();                                   // t+2
        id_md_read = 1; #1;
        expect_val("md_t2_stall_id", 1); expect_val("md_t2_bubble", 1);
        expect_val("md_t2_stall_ex", 0); expect_val("md_t2_busy", 1);
        check(stall_id); check(bubble_id); check(stall_ex); check(md_busy);
        expect_val("md_cnt_md", 1);
        step();                                   // t+3
        id_md_read = 0; #1;
        check(cnt_md);
        expect_val("md_t3_busy", 1); expect_val("md_t3_done", 0);
        check(md_busy); check(md_done);
        step();                                   // t+4
        expect_val("md_t4_busy", 1); expect_val("md_t4_done", 1);
        check(md_busy); check(md_done);
        step();                                   // t+5
        id_md_read = 1; #1;
        expect_val("md_t5_busy", 0); expect_val("md_t5_done", 0); expect_val("md_t5_stall_id", 0);
        check(md_busy); check(md_done); check(stall_id);
        expect_val("md_cnt_md_hold", 1);
        step();
        check(cnt_md);
        idle_inputs();

        // icache saturation and clear
        icache_stall = 1;
        expect_val("ic_sat", 15); expect_val("ic_sat_lu_hold", 1);
        repeat (19) step();
        check(cnt_ic); check(cnt_lu);
        perf_clr = 1;
        expect_val("clr_ic", 0); expect_val("clr_dc", 0);
        expect_val("clr_lu", 0); expect_val("clr_md", 0);
        step();
        perf_clr = 0;
        check(cnt_ic); check(cnt_dc); check(cnt_lu); check(cnt_md);
        expect_val("ic_after_clr", 1);
        step();
        check(cnt_ic);
        idle_inputs();
        step();

        // reset in the middle of an MD op
        id_md_start = 1;
        step();                                   // t+1
        id_md_start = 0; #1;
        expect_val("mdrst_t1_busy", 1); check(md_busy);
        step();                                   // t+2
        rst = 1; icache_stall = 1; dcache_stall = 1; id_md_read = 1; #1;
        expect_val("mdrst_stall_if", 0); expect_val("mdrst_stall_id", 0);
        expect_val("mdrst_bubble", 0);   expect_val("mdrst_stall_ex", 0);
        expect_val("mdrst_busy", 0);     expect_val("mdrst_done", 0);
        check(stall_if); check(stall_id); check(bubble_id); check(stall_ex);
        check(md_busy); check(md_done);
        step();                                   // t+3
        rst = 0; idle_inputs(); #1;
        expect_val("mdrst_t3_busy", 0); expect_val("mdrst_t3_done", 0);
        check(md_busy); check(md_done);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_val("mdrst_no_done", 0);
            check(md_done);
        end

        total++;
        assert (exp_q.size() === 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
